// File: rtl/leaf_arb_pkg.sv
// Shared types and helpers for the leaf write-bus arbiter.
package leaf_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Widest requester vector the index helper handles.
  localparam int MAX_REQ = 32;
  localparam int NUM_REQ_DEFAULT = 5;
  localparam int PTR_W = (NUM_REQ_DEFAULT > 1) ? $clog2(NUM_REQ_DEFAULT) : 1;

  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int onehot_to_idx(input logic [MAX_REQ-1:0] oh);
    int idx;
    idx = 0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (oh[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/leaf_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module rr_pick
  import leaf_arb_pkg::*;
#(
  parameter int NUM_REQ = 5,
  parameter int PTR_W   = 3
) (
  input  logic [NUM_REQ-1:0] req_eff,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] win,
  output logic [PTR_W-1:0]   win_idx,
  output logic               any
);

  logic [NUM_REQ-1:0] mask;
  logic [NUM_REQ-1:0] hi;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_mask
    assign mask[gi] = (PTR_W'(gi) >= ptr);
  end

  // Requests at/above the pointer take priority; otherwise wrap to the lowest.
  assign hi      = req_eff & mask;
  assign win     = (|hi) ? (hi & (~hi + NUM_REQ'(1)))
                         : (req_eff & (~req_eff + NUM_REQ'(1)));
  assign win_idx = PTR_W'(onehot_to_idx(MAX_REQ'(win)));
  assign any     = |req_eff;

endmodule

// File: rtl/leaf_wr_arbiter.sv
// Round-robin write-bus scheduler for the distributed leaf registers, plus registered XOR of leaf q.
// Optional stall abort is enabled with `define LEAF_ARB_TIMEOUT_EN.
module leaf_wr_arbiter
  import leaf_arb_pkg::*;
#(
  parameter int NUM_REQ = 5,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        gnt,
  output logic                      bus_valid,
  output logic [NUM_REQ-1:0]        bus_sel,
  output logic [DATA_W-1:0]         bus_data,
  input  logic                      bus_ready,
  input  logic [NUM_REQ-1:0]        leaf_q,
  output logic                      xor_q,
  output logic                      timeout_err
);

  localparam int PTR_W = ptr_width(NUM_REQ);

  if (NUM_REQ < 1 || NUM_REQ > MAX_REQ) begin : g_bad_num_req
    $error("leaf_wr_arbiter: NUM_REQ out of range");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("leaf_wr_arbiter: TIMEOUT must be at least 1");
  end

  state_t             state_reg;
  logic [PTR_W-1:0]   ptr_reg;
  logic [PTR_W-1:0]   ptr_adv;
  logic [NUM_REQ-1:0] req_eff;
  logic [NUM_REQ-1:0] win;
  logic [PTR_W-1:0]   win_idx;
  logic               win_any;
  logic [DATA_W-1:0]  win_data;
  int                 sel_idx;

  assign gnt     = (bus_valid && bus_ready) ? bus_sel : '0;
  assign req_eff = req & ~gnt;

  rr_pick #(
    .NUM_REQ(NUM_REQ),
    .PTR_W  (PTR_W)
  ) u_pick (
    .req_eff(req_eff),
    .ptr    (ptr_reg),
    .win    (win),
    .win_idx(win_idx),
    .any    (win_any)
  );

  assign win_data = req_data[int'(win_idx)*DATA_W +: DATA_W];

  // Pointer moves just past whichever leaf currently owns the bus.
  assign sel_idx = onehot_to_idx(MAX_REQ'(bus_sel));
  assign ptr_adv = (sel_idx == NUM_REQ - 1) ? '0 : PTR_W'(sel_idx + 1);

`ifdef LEAF_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] stall_cnt_reg;
`else
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      ptr_reg       <= '0;
      bus_valid     <= 1'b0;
      bus_sel       <= '0;
      bus_data      <= '0;
      xor_q         <= 1'b0;
`ifdef LEAF_ARB_TIMEOUT_EN
      timeout_err   <= 1'b0;
      stall_cnt_reg <= '0;
`endif
    end else begin
      xor_q <= ^leaf_q;
`ifdef LEAF_ARB_TIMEOUT_EN
      timeout_err <= 1'b0;
`endif
      case (state_reg)
        IDLE: begin
          if (win_any) begin
            bus_valid <= 1'b1;
            bus_sel   <= win;
            bus_data  <= win_data;
            state_reg <= BUSY;
          end
        end
        BUSY: begin
          if (bus_ready) begin
            ptr_reg <= ptr_adv;
`ifdef LEAF_ARB_TIMEOUT_EN
            stall_cnt_reg <= '0;
`endif
            // Back-to-back: next winner goes straight onto the bus.
            if (win_any) begin
              bus_sel  <= win;
              bus_data <= win_data;
            end else begin
              bus_valid <= 1'b0;
              bus_sel   <= '0;
              bus_data  <= '0;
              state_reg <= IDLE;
            end
          end
`ifdef LEAF_ARB_TIMEOUT_EN
          else if (stall_cnt_reg == CNT_W'(TIMEOUT - 1)) begin
            ptr_reg       <= ptr_adv;
            bus_valid     <= 1'b0;
            bus_sel       <= '0;
            bus_data      <= '0;
            timeout_err   <= 1'b1;
            stall_cnt_reg <= '0;
            state_reg     <= IDLE;
          end else begin
            stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
          end
`endif
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_leaf_wr_arbiter.sv
// Scoreboard bench for leaf_wr_arbiter: grants are matched against an expected-transfer queue.
module tb_leaf_wr_arbiter;

  localparam int N  = 5;
  localparam int W  = 8;
  localparam int TO = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic [N-1:0]   req;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   gnt;
  logic           bus_valid;
  logic [N-1:0]   bus_sel;
  logic [W-1:0]   bus_data;
  logic           bus_ready;
  logic [N-1:0]   leaf_q;
  logic           xor_q;
  logic           timeout_err;

  typedef struct {
    int           idx;
    logic [W-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  leaf_wr_arbiter #(
    .NUM_REQ(N),
    .DATA_W (W),
    .TIMEOUT(TO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .req_data   (req_data),
    .gnt        (gnt),
    .bus_valid  (bus_valid),
    .bus_sel    (bus_sel),
    .bus_data   (bus_data),
    .bus_ready  (bus_ready),
    .leaf_q     (leaf_q),
    .xor_q      (xor_q),
    .timeout_err(timeout_err)
  );

  // Scoreboard: every observed grant must match the oldest expected transfer.
  always @(negedge clk) begin
    exp_t         e;
    logic [N-1:0] eg;
    if (rst_n && gnt !== '0) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_gnt: gnt=%b data=%h, required no grant", gnt, bus_data);
      end else begin
        e = exp_q.pop_front();
        eg = '0;
        eg[e.idx] = 1'b1;
        if (gnt !== eg || bus_data !== e.data) begin
          errors++;
          $display("FAIL xfer: gnt=%b data=%h, required gnt=%b data=%h", gnt, bus_data, eg, e.data);
        end else begin
          $display("xfer leaf=%0d data=%h", e.idx, bus_data);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int i, input logic [W-1:0] d);
    req_data[i*W +: W] = d;
  endtask

  task automatic push_exp(input int i, input logic [W-1:0] d);
    exp_t e;
    e.idx = i;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus_valid, bus_sel, bus_data, xor_q, timeout_err, gnt} !== '0) begin
      errors++;
      $display("FAIL reset_state: valid=%b sel=%b data=%h xor=%b terr=%b gnt=%b, required all 0",
               bus_valid, bus_sel, bus_data, xor_q, timeout_err, gnt);
    end
    leaf_q = 5'b00001;
    req = 5'b00001;
    step();
    #1;
    checks++;
    if (xor_q !== 1'b0 || bus_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold: xor=%b valid=%b, required 0 0", xor_q, bus_valid);
    end
    req = '0;
    leaf_q = '0;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_async_reset();
    set_data(0, 8'h5A);
    req = 5'b00001;
    bus_ready = 1'b0;
    step();
    step();
    checks++;
    if (bus_valid !== 1'b1 || bus_sel !== 5'b00001) begin
      errors++;
      $display("FAIL busy_before_reset: valid=%b sel=%b, required 1 00001", bus_valid, bus_sel);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus_valid, bus_sel, bus_data, gnt, xor_q} !== '0) begin
      errors++;
      $display("FAIL async_reset: valid=%b sel=%b data=%h gnt=%b xor=%b, required all 0",
               bus_valid, bus_sel, bus_data, gnt, xor_q);
    end
    req = '0;
    bus_ready = 1'b1;
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single();
    set_data(2, 8'hA5);
    req = 5'b00100;
    bus_ready = 1'b1;
    push_exp(2, 8'hA5);
    step();
    #1;
    checks++;
    if (bus_valid !== 1'b1 || bus_sel !== 5'b00100 || bus_data !== 8'hA5 || gnt !== 5'b00100) begin
      errors++;
      $display("FAIL single_c1: valid=%b sel=%b data=%h gnt=%b, required 1 00100 a5 00100",
               bus_valid, bus_sel, bus_data, gnt);
    end
    step();
    req = '0;
    #1;
    checks++;
    if (bus_valid !== 1'b0 || bus_sel !== '0 || bus_data !== '0) begin
      errors++;
      $display("FAIL single_c2: valid=%b sel=%b data=%h, required 0 0 0", bus_valid, bus_sel, bus_data);
    end
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] oh;
    do_reset();
    for (int i = 0; i < N; i++) set_data(i, 8'(8'h10 + i));
    for (int n = 0; n < 6; n++) push_exp(n % N, 8'(8'h10 + (n % N)));
    req = 5'b11111;
    bus_ready = 1'b1;
    step();
    for (int n = 0; n < 6; n++) begin
      if (n == 5) req = '0;
      #1;
      oh = '0;
      oh[n % N] = 1'b1;
      checks++;
      if (gnt !== oh || bus_valid !== 1'b1) begin
        errors++;
        $display("FAIL rr_seq[%0d]: gnt=%b valid=%b, required %b 1", n, gnt, bus_valid, oh);
      end
      step();
    end
    #1;
    checks++;
    if (bus_valid !== 1'b0) begin
      errors++;
      $display("FAIL rr_drain: valid=%b, required 0", bus_valid);
    end
  endtask

  task automatic test_stall();
    set_data(1, 8'h3C);
    req = 5'b00010;
    bus_ready = 1'b0;
    push_exp(1, 8'h3C);
    step();
    for (int c = 1; c <= 3; c++) begin
      #1;
      checks++;
      if (bus_valid !== 1'b1 || bus_sel !== 5'b00010 || bus_data !== 8'h3C || gnt !== '0) begin
        errors++;
        $display("FAIL stall_hold[%0d]: valid=%b sel=%b data=%h gnt=%b, required 1 00010 3c 00000",
                 c, bus_valid, bus_sel, bus_data, gnt);
      end
      step();
    end
    bus_ready = 1'b1;
    #1;
    checks++;
    if (gnt !== 5'b00010) begin
      errors++;
      $display("FAIL stall_gnt: gnt=%b, required 00010", gnt);
    end
    step();
    req = '0;
    #1;
    checks++;
    if (bus_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_done: valid=%b, required 0", bus_valid);
    end
  endtask

  task automatic test_xor();
    logic [N-1:0] pat [5];
    logic         prev;
    pat[0] = 5'b10110;
    pat[1] = 5'b00000;
    pat[2] = 5'b11000;
    pat[3] = 5'b00001;
    pat[4] = 5'b11111;
    prev = 1'b0;
    for (int k = 0; k < 5; k++) begin
      leaf_q = pat[k];
      #1;
      checks++;
      if (xor_q !== prev) begin
        errors++;
        $display("FAIL xor_latency[%0d]: xor=%b, required %b", k, xor_q, prev);
      end
      step();
      prev = ^pat[k];
      checks++;
      if (xor_q !== prev) begin
        errors++;
        $display("FAIL xor_value[%0d]: leaf_q=%b xor=%b, required %b", k, pat[k], xor_q, prev);
      end
    end
    leaf_q = '0;
    step();
  endtask

`ifdef LEAF_ARB_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    set_data(0, 8'hC0);
    set_data(1, 8'hC1);
    req = 5'b00011;
    bus_ready = 1'b0;
    step();
    for (int c = 1; c <= TO; c++) begin
      #1;
      checks++;
      if (bus_valid !== 1'b1 || bus_sel !== 5'b00001 || timeout_err !== 1'b0) begin
        errors++;
        $display("FAIL to_stall[%0d]: valid=%b sel=%b terr=%b, required 1 00001 0",
                 c, bus_valid, bus_sel, timeout_err);
      end
      step();
    end
    #1;
    checks++;
    if (timeout_err !== 1'b1 || bus_valid !== 1'b0 || gnt !== '0) begin
      errors++;
      $display("FAIL to_abort: terr=%b valid=%b gnt=%b, required 1 0 00000", timeout_err, bus_valid, gnt);
    end
    step();
    #1;
    checks++;
    if (bus_valid !== 1'b1 || bus_sel !== 5'b00010 || timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL to_next: valid=%b sel=%b terr=%b, required 1 00010 0", bus_valid, bus_sel, timeout_err);
    end
    push_exp(1, 8'hC1);
    push_exp(0, 8'hC0);
    bus_ready = 1'b1;
    step();
    req = '0;
    #1;
    checks++;
    if (bus_sel !== 5'b00001 || gnt !== 5'b00001) begin
      errors++;
      $display("FAIL to_retry: sel=%b gnt=%b, required 00001 00001", bus_sel, gnt);
    end
    step();
    #1;
    checks++;
    if (bus_valid !== 1'b0) begin
      errors++;
      $display("FAIL to_drain: valid=%b, required 0", bus_valid);
    end
  endtask
`else
  task automatic test_timeout();
    do_reset();
    set_data(0, 8'h77);
    req = 5'b00001;
    bus_ready = 1'b0;
    step();
    for (int c = 1; c <= 3 * TO; c++) begin
      #1;
      checks++;
      if (bus_valid !== 1'b1 || timeout_err !== 1'b0) begin
        errors++;
        $display("FAIL no_timeout[%0d]: valid=%b terr=%b, required 1 0", c, bus_valid, timeout_err);
      end
      step();
    end
    push_exp(0, 8'h77);
    bus_ready = 1'b1;
    step();
    req = '0;
    #1;
    checks++;
    if (bus_valid !== 1'b0) begin
      errors++;
      $display("FAIL no_timeout_drain: valid=%b, required 0", bus_valid);
    end
  endtask
`endif

  initial begin
    req = '0;
    req_data = '0;
    bus_ready = 1'b0;
    leaf_q = '0;
    test_reset();
    test_async_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_xor();
    test_timeout();
    step();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_empty: %0d transfers outstanding, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
